// File: rtl/nvdla_dbb_rd_arb_pkg.sv
// Shared constants, types and helpers for the dbb read-port arbiter.
package nvdla_dbb_pkg;

  localparam int unsigned DBB_ID_W   = 8;
  localparam logic [2:0]  DBB_ARSIZE = 3'b011;
  localparam int unsigned DBB_LEN_W  = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Width of a per-client outstanding counter able to hold 0..max_outs.
  function automatic int unsigned outs_cnt_w(input int unsigned max_outs);
    return $clog2(max_outs + 1);
  endfunction

endpackage

// File: rtl/nvdla_dbb_rd_arb_if.sv
// Client-side and dbb-side AR/R signals of the dbb read arbiter.
interface nvdla_dbb_rd_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64
);
  import nvdla_dbb_pkg::*;

  logic [NUM_REQ-1:0]           req_ar_valid;
  logic [NUM_REQ-1:0]           req_ar_ready;
  logic [NUM_REQ*AW-1:0]        req_ar_addr;
  logic [NUM_REQ*DBB_LEN_W-1:0] req_ar_len;
  logic [NUM_REQ-1:0]           req_r_valid;
  logic [NUM_REQ-1:0]           req_r_ready;
  logic [DW-1:0]                req_r_data;
  logic                         req_r_last;

  logic                         dbb_ar_arvalid;
  logic                         dbb_ar_arready;
  logic [AW-1:0]                dbb_ar_araddr;
  logic [DBB_ID_W-1:0]          dbb_ar_arid;
  logic [DBB_LEN_W-1:0]         dbb_ar_arlen;
  logic [2:0]                   dbb_ar_arsize;
  logic                         dbb_r_rvalid;
  logic                         dbb_r_rready;
  logic [DBB_ID_W-1:0]          dbb_r_rid;
  logic                         dbb_r_rlast;
  logic [DW-1:0]                dbb_r_rdata;

  // Arbiter view.
  modport slave (
    input  req_ar_valid, req_ar_addr, req_ar_len, req_r_ready,
    input  dbb_ar_arready, dbb_r_rvalid, dbb_r_rid, dbb_r_rlast, dbb_r_rdata,
    output req_ar_ready, req_r_valid, req_r_data, req_r_last,
    output dbb_ar_arvalid, dbb_ar_araddr, dbb_ar_arid, dbb_ar_arlen, dbb_ar_arsize,
    output dbb_r_rready
  );

  // Environment view (clients plus dbb).
  modport master (
    output req_ar_valid, req_ar_addr, req_ar_len, req_r_ready,
    output dbb_ar_arready, dbb_r_rvalid, dbb_r_rid, dbb_r_rlast, dbb_r_rdata,
    input  req_ar_ready, req_r_valid, req_r_data, req_r_last,
    input  dbb_ar_arvalid, dbb_ar_araddr, dbb_ar_arid, dbb_ar_arlen, dbb_ar_arsize,
    input  dbb_r_rready
  );

endinterface

// File: rtl/nvdla_dbb_rd_arb_rr.sv
// Round-robin grant: first eligible client at or above ptr, wrapping.
module nvdla_rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int unsigned best_idx;
  int unsigned best_rank;
  int unsigned rank;

  // Rank each client by distance from ptr; the lowest eligible rank wins.
  always_comb begin
    best_idx  = 0;
    best_rank = N;
    rank      = 0;
    grant     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rank = (i + N - int'(ptr)) % N;
      if (elig[i] && (rank < best_rank)) begin
        best_rank = rank;
        best_idx  = i;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      grant[i] = (best_rank < N) && (best_idx == i);
    end
  end

endmodule

// File: rtl/nvdla_dbb_rd_arb.sv
// Round-robin sharing of the dbb AXI read port among NUM_REQ clients.
// AR goes through a one-entry output slot tagged with the client index;
// R beats are steered back combinationally by rid.
// Optional macro NVDLA_DBB_RD_ARB_PERF_EN enables per-client AR stall counters.
module nvdla_dbb_rd_arb
  import nvdla_dbb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned AW       = 64,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAX_OUTS = 8
) (
  input  logic                  core_clk,
  input  logic                  rstn,
  nvdla_dbb_rd_arb_if.slave     bus,
  output logic                  err_unexp_rid,
  output logic [NUM_REQ*32-1:0] perf_stall_cnt
);

  localparam int unsigned    PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned    CW    = outs_cnt_w(MAX_OUTS);
  localparam logic [CW-1:0]  MAX_C = CW'(MAX_OUTS);

  slot_state_e            slot_q;
  logic [PW-1:0]          ptr_q;
  logic                   arvalid_q;
  logic [AW-1:0]          araddr_q;
  logic [DBB_ID_W-1:0]    arid_q;
  logic [DBB_LEN_W-1:0]   arlen_q;
  logic [CW-1:0]          cnt_q [NUM_REQ];
  logic                   err_q;

  logic [NUM_REQ-1:0]     elig, grant, ar_ready, ar_inc, r_hit, r_dec;
  logic                   slot_free, ar_hs, rid_ok, sel_r_ready, r_ready, r_fire;
  logic [PW-1:0]          g_idx;
  logic [AW-1:0]          g_addr;
  logic [DBB_LEN_W-1:0]   g_len;
  logic [DW-1:0]          r_data;

  // Decode rid: a beat is routable only for an existing client with bursts in flight.
  always_comb begin
    r_hit       = '0;
    rid_ok      = 1'b0;
    sel_r_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      r_hit[i] = (bus.dbb_r_rid == DBB_ID_W'(i));
      if (r_hit[i]) begin
        rid_ok      = (cnt_q[i] != '0);
        sel_r_ready = bus.req_r_ready[i];
      end
    end
  end

  // Unroutable beats are drained so they cannot block the channel.
  assign r_ready = rstn & (rid_ok ? sel_r_ready : 1'b1);
  assign r_fire  = bus.dbb_r_rvalid & r_ready;
  assign r_dec   = r_hit & {NUM_REQ{r_fire & bus.dbb_r_rlast & rid_ok}};

  // A retiring last beat frees its client's credit in the same cycle.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_ar_valid[i] & ((cnt_q[i] < MAX_C) | r_dec[i]);
    end
  end

  nvdla_rr_arb #(.N(NUM_REQ), .PW(PW)) u_rr (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign slot_free = rstn & ((slot_q == SLOT_EMPTY) | bus.dbb_ar_arready);
  assign ar_ready  = grant & {NUM_REQ{slot_free}};
  assign ar_inc    = ar_ready & bus.req_ar_valid;
  assign ar_hs     = |ar_inc;

  // Select the granted client's request fields.
  always_comb begin
    g_idx  = '0;
    g_addr = '0;
    g_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_idx  = PW'(i);
        g_addr = bus.req_ar_addr[i*AW +: AW];
        g_len  = bus.req_ar_len[i*DBB_LEN_W +: DBB_LEN_W];
      end
    end
  end

  // AR output slot; a new grant may refill it in the cycle the dbb drains it.
  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      slot_q    <= SLOT_EMPTY;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      arlen_q   <= '0;
      ptr_q     <= '0;
    end else if (ar_hs) begin
      slot_q    <= SLOT_FULL;
      arvalid_q <= 1'b1;
      araddr_q  <= g_addr;
      arid_q    <= DBB_ID_W'(g_idx);
      arlen_q   <= g_len;
      ptr_q     <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
    end else if ((slot_q == SLOT_FULL) && bus.dbb_ar_arready) begin
      slot_q    <= SLOT_EMPTY;
      arvalid_q <= 1'b0;
    end
  end

  // Outstanding bursts per client: +1 on AR accept, -1 on last R beat.
  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ar_inc[i] && !r_dec[i]) cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (!ar_inc[i] && r_dec[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
      end
    end
  end

  // Sticky flag for beats carrying an unknown or idle rid.
  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else if (bus.dbb_r_rvalid && !rid_ok) err_q <= 1'b1;
  end

`ifdef NVDLA_DBB_RD_ARB_PERF_EN
  logic [31:0] stall_q [NUM_REQ];

  // Saturating count of cycles a client requests but is not accepted.
  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) stall_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ar_valid[i] && !ar_inc[i] && (stall_q[i] != '1))
          stall_q[i] <= stall_q[i] + 32'd1;
      end
    end
  end

  // Pack counters onto the flat output.
  always_comb begin
    perf_stall_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) perf_stall_cnt[i*32 +: 32] = stall_q[i];
  end
`else
  assign perf_stall_cnt = '0;
`endif

  assign r_data             = bus.dbb_r_rdata;
  assign bus.req_ar_ready   = ar_ready;
  assign bus.req_r_valid    = r_hit & {NUM_REQ{bus.dbb_r_rvalid & rid_ok}};
  assign bus.req_r_data     = r_data;
  assign bus.req_r_last     = bus.dbb_r_rlast;
  assign bus.dbb_ar_arvalid = arvalid_q;
  assign bus.dbb_ar_araddr  = araddr_q;
  assign bus.dbb_ar_arid    = arid_q;
  assign bus.dbb_ar_arlen   = arlen_q;
  assign bus.dbb_ar_arsize  = DBB_ARSIZE;
  assign bus.dbb_r_rready   = r_ready;
  assign err_unexp_rid      = err_q;

endmodule

// File: tb/tb_nvdla_dbb_rd_arb.sv
// Self-checking bench for nvdla_dbb_rd_arb: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_nvdla_dbb_rd_arb;
  import nvdla_dbb_pkg::*;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned AW       = 64;
  localparam int unsigned DW       = 64;
  localparam int unsigned MAX_OUTS = 8;

  logic                  core_clk = 1'b0;
  logic                  rstn;
  logic                  err_unexp_rid;
  logic [NUM_REQ*32-1:0] perf_stall_cnt;

  always #5 core_clk = ~core_clk;

  nvdla_dbb_rd_arb_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  nvdla_dbb_rd_arb #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .MAX_OUTS(MAX_OUTS)) dut (
    .core_clk       (core_clk),
    .rstn           (rstn),
    .bus            (bus),
    .err_unexp_rid  (err_unexp_rid),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // Reference model state.
  typedef struct { logic [AW-1:0] addr; int unsigned len; int unsigned id; } ar_t;
  typedef struct { int unsigned id; int unsigned len; } rb_t;
  ar_t             ar_q[$];
  rb_t             r_pend[$];
  int unsigned     beat;
  int unsigned     outs [NUM_REQ];
  int unsigned     ptr_m;
  bit              err_m;
  longint unsigned stall_m [NUM_REQ];
  bit              r_hold;

  logic [NUM_REQ-1:0] exp_ar_ready, exp_r_valid;
  logic               exp_rready;
  int                 g_m;
  bit                 slot_free_m, rid_ok_m;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ar_q.delete();
    r_pend.delete();
    beat   = 0;
    ptr_m  = 0;
    err_m  = 1'b0;
    r_hold = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      outs[i]    = 0;
      stall_m[i] = 0;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input int unsigned l);
    bus.req_ar_valid[i]         = v;
    bus.req_ar_addr[i*AW +: AW] = a;
    bus.req_ar_len[i*4 +: 4]    = 4'(l);
  endtask

  // Expected combinational responses from the current inputs and model state.
  task automatic predict();
    int unsigned        rid_i;
    int unsigned        left;
    int unsigned        c;
    bit                 drop;
    logic [NUM_REQ-1:0] elig_m;
    rid_i    = bus.dbb_r_rid;
    rid_ok_m = (rstn === 1'b1) && (rid_i < NUM_REQ) && (outs[rid_i] > 0);
    exp_rready = (rstn !== 1'b1) ? 1'b0 : (rid_ok_m ? bus.req_r_ready[rid_i] : 1'b1);
    exp_r_valid = '0;
    if (bus.dbb_r_rvalid && rid_ok_m) exp_r_valid[rid_i] = 1'b1;
    elig_m = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop = bus.dbb_r_rvalid && exp_rready && bus.dbb_r_rlast && rid_ok_m && (rid_i == i);
      left = outs[i] - (drop ? 1 : 0);
      elig_m[i] = bus.req_ar_valid[i] && (left < MAX_OUTS);
    end
    slot_free_m = (rstn === 1'b1) && ((ar_q.size() == 0) || bus.dbb_ar_arready);
    g_m = -1;
    for (int off = 0; off < NUM_REQ; off++) begin
      c = (ptr_m + off) % NUM_REQ;
      if (g_m < 0 && elig_m[c]) g_m = int'(c);
    end
    exp_ar_ready = '0;
    if (slot_free_m && g_m >= 0) exp_ar_ready[g_m] = 1'b1;
  endtask

  // Called at a falling edge with inputs set: check, cross the rising edge,
  // advance the model, and return at the next falling edge.
  task automatic tick();
    logic [NUM_REQ*32-1:0] exp_perf;
    ar_t                   ar;
    int unsigned           rid_i;
    #1;
    predict();
    chk("ar_ready", bus.req_ar_ready, exp_ar_ready);
    chk("arvalid", bus.dbb_ar_arvalid, ar_q.size() != 0);
    if (ar_q.size() != 0) begin
      chk("araddr", bus.dbb_ar_araddr, ar_q[0].addr);
      chk("arid", bus.dbb_ar_arid, ar_q[0].id);
      chk("arlen", bus.dbb_ar_arlen, ar_q[0].len);
    end
    chk("arsize", bus.dbb_ar_arsize, 3'b011);
    chk("r_valid", bus.req_r_valid, exp_r_valid);
    chk("rready", bus.dbb_r_rready, exp_rready);
    chk("r_data", bus.req_r_data, bus.dbb_r_rdata);
    chk("r_last", bus.req_r_last, bus.dbb_r_rlast);
    chk("err", err_unexp_rid, err_m);
    exp_perf = '0;
`ifdef NVDLA_DBB_RD_ARB_PERF_EN
    for (int i = 0; i < NUM_REQ; i++)
      exp_perf[i*32 +: 32] = (stall_m[i] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(stall_m[i]);
`endif
    chk("perf", perf_stall_cnt, exp_perf);
    @(posedge core_clk);
    if (ar_q.size() != 0 && bus.dbb_ar_arready) begin
      ar = ar_q.pop_front();
      r_pend.push_back('{id: ar.id, len: ar.len});
    end
    if (slot_free_m && g_m >= 0) begin
      ar_q.push_back('{addr: bus.req_ar_addr[g_m*AW +: AW],
                       len:  bus.req_ar_len[g_m*4 +: 4],
                       id:   g_m});
      outs[g_m]++;
      ptr_m = (g_m + 1) % NUM_REQ;
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.req_ar_valid[i] && !(slot_free_m && g_m == i)) stall_m[i]++;
    rid_i = bus.dbb_r_rid;
    if (bus.dbb_r_rvalid && exp_rready && rid_ok_m) begin
      if (bus.dbb_r_rlast) outs[rid_i]--;
      if (r_pend.size() != 0 && r_pend[0].id == rid_i) begin
        if (bus.dbb_r_rlast) begin
          void'(r_pend.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
    end
    if (bus.dbb_r_rvalid && !rid_ok_m) err_m = 1'b1;
    r_hold = bus.dbb_r_rvalid && !exp_rready;
    @(negedge core_clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge core_clk);
    model_reset();
    rstn = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 15));
    bus.dbb_ar_arready = ($urandom_range(0, 3) != 0);
    bus.req_r_ready    = NUM_REQ'($urandom);
    if (!r_hold) begin
      if (r_pend.size() != 0 && $urandom_range(0, 1) == 1) begin
        bus.dbb_r_rvalid = 1'b1;
        bus.dbb_r_rid    = 8'(r_pend[0].id);
        bus.dbb_r_rlast  = (beat == r_pend[0].len);
      end else begin
        bus.dbb_r_rvalid = 1'b0;
        bus.dbb_r_rid    = 8'($urandom_range(0, NUM_REQ - 1));
        bus.dbb_r_rlast  = 1'($urandom);
      end
      bus.dbb_r_rdata = {$urandom, $urandom};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ar_t snap;
    int  ps;
    logic [31:0] exp_p0;

    // Reset with stimulus active.
    rstn = 1'b0;
    model_reset();
    set_req(0, 1'b1, 64'hAAAA_0000, 5);
    set_req(1, 1'b1, 64'hBBBB_0000, 7);
    bus.dbb_ar_arready = 1'b1;
    bus.dbb_r_rvalid   = 1'b0;
    bus.dbb_r_rid      = '0;
    bus.dbb_r_rlast    = 1'b0;
    bus.dbb_r_rdata    = '0;
    bus.req_r_ready    = '1;
    repeat (3) @(negedge core_clk);
    #1;
    chk("rst_arvalid", bus.dbb_ar_arvalid, 1'b0);
    chk("rst_araddr", bus.dbb_ar_araddr, 64'h0);
    chk("rst_arid", bus.dbb_ar_arid, 8'h0);
    chk("rst_arlen", bus.dbb_ar_arlen, 4'h0);
    chk("rst_ar_ready", bus.req_ar_ready, 2'b00);
    chk("rst_r_valid", bus.req_r_valid, 2'b00);
    chk("rst_rready", bus.dbb_r_rready, 1'b0);
    chk("rst_err", err_unexp_rid, 1'b0);
    chk("rst_perf", perf_stall_cnt, 64'h0);
    @(negedge core_clk);
    rstn = 1'b1;
    bus.req_ar_valid = '0;
    bus.req_r_ready  = '0;
    tick();

    // 1: single client 0 request.
    set_req(0, 1'b1, 64'h1000, 3);
    tick();
    #1;
    chk("t1_arvalid", bus.dbb_ar_arvalid, 1'b1);
    chk("t1_araddr", bus.dbb_ar_araddr, 64'h1000);
    chk("t1_arid", bus.dbb_ar_arid, 8'h0);
    chk("t1_arlen", bus.dbb_ar_arlen, 4'h3);
    chk("t1_arsize", bus.dbb_ar_arsize, 3'b011);
    bus.req_ar_valid = '0;
    tick();

    // 2: both clients continuously valid, dbb always ready.
    set_req(0, 1'b1, 64'h2000, 1);
    set_req(1, 1'b1, 64'h3000, 2);
    ps = int'(ptr_m);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_arvalid", bus.dbb_ar_arvalid, 1'b1);
      chk("t2_arid", bus.dbb_ar_arid, (ps + k) % NUM_REQ);
    end

    // 3: dbb stalls AR for 5 cycles.
    bus.dbb_ar_arready = 1'b0;
    snap = ar_q[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_arvalid", bus.dbb_ar_arvalid, 1'b1);
      chk("t3_araddr", bus.dbb_ar_araddr, snap.addr);
      chk("t3_arid", bus.dbb_ar_arid, snap.id);
      chk("t3_ar_ready", bus.req_ar_ready, 2'b00);
    end
    bus.req_ar_valid   = '0;
    bus.dbb_ar_arready = 1'b1;
    tick();

    // 4: client 1 fills its outstanding limit, then a last beat frees it.
    set_req(1, 1'b1, 64'h4000, 0);
    for (int k = 0; k < 20 && outs[1] < MAX_OUTS; k++) tick();
    #1;
    chk("t4_blocked", bus.req_ar_ready, 2'b00);
    tick();
    bus.dbb_r_rvalid = 1'b1;
    bus.dbb_r_rid    = 8'd1;
    bus.dbb_r_rlast  = 1'b1;
    bus.dbb_r_rdata  = 64'hDEAD_BEEF_0000_0001;
    bus.req_r_ready  = 2'b10;
    #1;
    chk("t4_reopen", bus.req_ar_ready, 2'b10);
    chk("t4_rready", bus.dbb_r_rready, 1'b1);
    tick();
    bus.dbb_r_rvalid = 1'b0;
    bus.req_ar_valid = '0;
    tick();

    // 5: R beat back-pressured by the client.
    bus.dbb_r_rvalid = 1'b1;
    bus.dbb_r_rid    = 8'd1;
    bus.dbb_r_rlast  = 1'b0;
    bus.dbb_r_rdata  = 64'h1234_5678_9ABC_DEF0;
    bus.req_r_ready  = 2'b00;
    #1;
    chk("t5_r_valid", bus.req_r_valid, 2'b10);
    chk("t5_rready_lo", bus.dbb_r_rready, 1'b0);
    tick();
    bus.req_r_ready = 2'b10;
    #1;
    chk("t5_rready_hi", bus.dbb_r_rready, 1'b1);
    tick();

    // 6: unexpected rid is drained and flagged.
    bus.dbb_r_rid   = 8'd5;
    bus.dbb_r_rlast = 1'b1;
    bus.req_r_ready = 2'b00;
    #1;
    chk("t6_rready", bus.dbb_r_rready, 1'b1);
    chk("t6_r_valid", bus.req_r_valid, 2'b00);
    tick();
    bus.dbb_r_rvalid = 1'b0;
    #1;
    chk("t6_err_set", err_unexp_rid, 1'b1);
    repeat (3) tick();
    chk("t6_err_sticky", err_unexp_rid, 1'b1);

    // Stall counter: one accepted request, then four stalled cycles.
    bus.req_ar_valid = '0;
    bus.dbb_r_rvalid = 1'b0;
    do_reset();
    bus.dbb_ar_arready = 1'b0;
    set_req(0, 1'b1, 64'h5000, 2);
    tick();
    repeat (4) tick();
`ifdef NVDLA_DBB_RD_ARB_PERF_EN
    exp_p0 = 32'd4;
`else
    exp_p0 = 32'd0;
`endif
    chk("perf_stall0", perf_stall_cnt[31:0], exp_p0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
